// File: rtl/bits_pkg.sv
// Shared constants, state encoding and sizing helper for the BITS literal encoder.
// Optional build macro used by the encoder: BITS_ENC_FULL_WIDTH_EN.
package bits_pkg;

    localparam logic [2:0] PKT_TYPE_LITERAL = 3'd4;
    localparam int         HDR_W            = 6;
    localparam int         GRP_W            = 5;
    localparam int         NIB_W            = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        SEND = 2'd2
    } state_t;

    // Bytes needed for the longest literal packet of a given value width.
    function automatic int max_bytes(input int value_w);
        return (HDR_W + GRP_W * (value_w / 4) + 7) / 8;
    endfunction

endpackage

// File: rtl/bits_nibble_count.sv
// Leading-nibble priority encoder: number of significant nibbles in value,
// never less than one so that a zero value still produces one group.
module bits_nibble_count
    import bits_pkg::*;
#(
    parameter int VALUE_W = 64
) (
    input  logic [VALUE_W-1:0] value,
    output logic [NIB_W-1:0]   n
);

    localparam int MAX_NIB = VALUE_W / 4;

    always_comb begin
        n = NIB_W'(1);
        for (int i = 1; i < MAX_NIB; i++) begin
            if (value[4*i +: 4] != 4'd0) begin
                n = NIB_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/bits_literal_encoder.sv
// Serialises one BITS literal packet (type 4) per request as an MSB-first byte
// stream. Define BITS_ENC_FULL_WIDTH_EN to always send every nibble of the value.
module bits_literal_encoder
    import bits_pkg::*;
#(
    parameter int VALUE_W = 64
) (
    input  logic               clk,
    input  logic               resetB,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [2:0]         req_version,
    input  logic [VALUE_W-1:0] req_value,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [7:0]         tx_data,
    output logic               tx_last,
    output logic [15:0]        pkt_count,
    output logic [15:0]        version_sum,
    output state_t             state
);

    localparam int MAX_NIB   = VALUE_W / 4;
    localparam int MAX_BYTES = max_bytes(VALUE_W);
    localparam int SR_W      = MAX_BYTES * 8;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);

    // Handshakes: a request transfers on req_valid & req_ready at a rising edge;
    // a byte transfers on tx_valid & tx_ready, and tx_valid/tx_data/tx_last stay
    // put until that happens.

    logic [2:0]         ver_q;
    logic [VALUE_W-1:0] val_q;
    logic [SR_W-1:0]    sr;
    logic [CNT_W-1:0]   bytes_left;

    logic [NIB_W-1:0]   n_sel;
    logic [VALUE_W-1:0] aligned;
    logic [SR_W-1:0]    pkt;
    logic [CNT_W-1:0]   nbytes;

`ifdef BITS_ENC_FULL_WIDTH_EN
    assign n_sel = NIB_W'(MAX_NIB);
`else
    bits_nibble_count #(
        .VALUE_W(VALUE_W)
    ) u_nibble_count (
        .value(val_q),
        .n    (n_sel)
    );
`endif

    // Shift the value so its most significant sent nibble sits at the top;
    // group i then always reads a fixed slice of aligned.
    assign aligned = val_q << (4 * (MAX_NIB - int'(n_sel)));

    always_comb begin
        pkt = '0;
        pkt[SR_W-1 -: HDR_W] = {ver_q, PKT_TYPE_LITERAL};
        for (int i = 0; i < MAX_NIB; i++) begin
            if (i < int'(n_sel)) begin
                pkt[SR_W-1-HDR_W-GRP_W*i -: GRP_W] =
                    {(i < int'(n_sel) - 1), aligned[VALUE_W-1-4*i -: 4]};
            end
        end
    end

    assign nbytes    = CNT_W'((HDR_W + GRP_W * int'(n_sel) + 7) / 8);
    assign req_ready = (state == IDLE);
    assign tx_data   = sr[SR_W-1 -: 8];

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            state       <= IDLE;
            ver_q       <= '0;
            val_q       <= '0;
            sr          <= '0;
            bytes_left  <= '0;
            tx_valid    <= 1'b0;
            tx_last     <= 1'b0;
            pkt_count   <= '0;
            version_sum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ver_q <= req_version;
                        val_q <= req_value;
                        state <= PACK;
                    end
                end
                PACK: begin
                    sr         <= pkt;
                    bytes_left <= nbytes;
                    tx_valid   <= 1'b1;
                    tx_last    <= (nbytes == CNT_W'(1));
                    state      <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        sr         <= sr << 8;
                        bytes_left <= bytes_left - CNT_W'(1);
                        tx_last    <= (bytes_left == CNT_W'(2));
                        if (bytes_left == CNT_W'(1)) begin
                            tx_valid    <= 1'b0;
                            tx_last     <= 1'b0;
                            pkt_count   <= pkt_count + 16'd1;
                            version_sum <= version_sum + 16'(ver_q);
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bits_literal_encoder.sv
// Self-checking bench for bits_literal_encoder: byte scoreboard, stall holding,
// back-to-back spacing, mid-packet reset and randomised values.
module tb_bits_literal_encoder;
    import bits_pkg::*;

    logic        clk = 1'b0;
    logic        resetB = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_version = '0;
    logic [63:0] req_value = '0;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic [15:0] pkt_count;
    logic [15:0] version_sum;
    state_t      state;

    bits_literal_encoder #(.VALUE_W(64)) dut (
        .clk        (clk),
        .resetB     (resetB),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_version(req_version),
        .req_value  (req_value),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_last    (tx_last),
        .pkt_count  (pkt_count),
        .version_sum(version_sum),
        .state      (state)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    logic [8:0] exp_q[$];
    int gap_q[$];
    int exp_pkt = 0;
    int exp_vsum = 0;

    // scoreboard model: {last, byte} for each byte of the expected packet
    task automatic push_model(input logic [2:0] ver, input logic [63:0] val);
        logic bits[$];
        logic [7:0] byte_v;
        int n;
        n = 1;
        for (int i = 0; i < 16; i++) if (val[4*i +: 4] != 4'd0) n = i + 1;
`ifdef BITS_ENC_FULL_WIDTH_EN
        n = 16;
`endif
        bits.push_back(ver[2]);
        bits.push_back(ver[1]);
        bits.push_back(ver[0]);
        bits.push_back(1'b1);
        bits.push_back(1'b0);
        bits.push_back(1'b0);
        for (int g = n - 1; g >= 0; g--) begin
            bits.push_back(g != 0);
            for (int b = 3; b >= 0; b--) bits.push_back(val[4*g + b]);
        end
        while (bits.size() % 8 != 0) bits.push_back(1'b0);
        for (int i = 0; i < bits.size(); i += 8) begin
            byte_v = 8'h00;
            for (int b = 0; b < 8; b++) byte_v = {byte_v[6:0], bits[i + b]};
            exp_q.push_back({(i + 8 == bits.size()), byte_v});
        end
    endtask

    task automatic monitor();
        logic [8:0] e;
        logic [8:0] held = '0;
        logic held_v = 1'b0;
        logic prev_last = 1'b0;
        int prev_cyc = 0;
        forever begin
            @(negedge clk);
            if (resetB && held_v) begin
                total++;
                if (!tx_valid || {tx_last, tx_data} !== held) begin
                    bad++;
                    $display("FAIL hold: got valid=%0b last/data=%h required valid=1 last/data=%h",
                             tx_valid, {tx_last, tx_data}, held);
                end
            end
            held_v = resetB && tx_valid && !tx_ready;
            held   = {tx_last, tx_data};
            if (!resetB) prev_last = 1'b0;
            if (resetB && tx_valid && tx_ready) begin
                if (prev_last) gap_q.push_back(cyc - prev_cyc - 1);
                prev_cyc  = cyc;
                prev_last = tx_last;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL byte: got last/data=%h required none (queue empty)", {tx_last, tx_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({tx_last, tx_data} !== e) begin
                        bad++;
                        $display("FAIL byte: got last/data=%h required %h", {tx_last, tx_data}, e);
                    end
                end
            end
        end
    endtask

    // driver tasks
    task automatic send_req(input logic [2:0] ver, input logic [63:0] val, output int pres);
        int k;
        k = 0;
        while (!req_ready && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 300) begin
            total++;
            bad++;
            $display("FAIL req_ready_timeout: got 0 required 1");
        end
        req_version = ver;
        req_value   = val;
        req_valid   = 1'b1;
        pres        = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_pkt++;
        exp_vsum += int'(ver);
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!tx_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (!tx_valid) begin
            bad++;
            $display("FAIL tx_valid_timeout: got 0 required 1");
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(state == IDLE && exp_q.size() == 0) && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (k >= 300) begin
            bad++;
            $display("FAIL idle_timeout: got state=%0d left=%0d required IDLE/0", state, exp_q.size());
        end
    endtask

    task automatic check_counters(input string name);
        total++;
        if (pkt_count !== 16'(exp_pkt)) begin
            bad++;
            $display("FAIL %s_pkt_count: got %0d required %0d", name, pkt_count, exp_pkt);
        end
        total++;
        if (version_sum !== 16'(exp_vsum)) begin
            bad++;
            $display("FAIL %s_version_sum: got %0d required %0d", name, version_sum, exp_vsum);
        end
    endtask

    task automatic do_reset();
        resetB = 1'b0;
        @(posedge clk); #1;
        resetB = 1'b1;
        exp_q.delete();
        exp_pkt  = 0;
        exp_vsum = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d required 0", state); end
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
        total++;
        if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b required 0", tx_valid); end
        total++;
        if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h required 00", tx_data); end
        total++;
        if (tx_last !== 1'b0) begin bad++; $display("FAIL reset_tx_last: got %b required 0", tx_last); end
        check_counters("reset");
        resetB = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic push_7e5();
`ifdef BITS_ENC_FULL_WIDTH_EN
        push_model(3'd6, 64'h7E5);
`else
        exp_q.push_back(9'h0D2);
        exp_q.push_back(9'h0FE);
        exp_q.push_back(9'h128);
`endif
    endtask

    task automatic test_basic();
        int pres;
        tx_ready = 1'b1;
        push_7e5();
        send_req(3'd6, 64'h7E5, pres);
        wait_valid();
        total++;
        if (cyc - pres != 2) begin
            bad++;
            $display("FAIL basic_latency: got %0d required 2", cyc - pres);
        end
        wait_idle();
        check_counters("basic");
        total++;
        if (tx_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_idle: got valid=%b ready=%b required 0/1", tx_valid, req_ready);
        end
    endtask

    task automatic test_zero();
        int pres;
        tx_ready = 1'b1;
`ifdef BITS_ENC_FULL_WIDTH_EN
        push_model(3'd0, 64'h0);
`else
        exp_q.push_back(9'h010);
        exp_q.push_back(9'h100);
`endif
        send_req(3'd0, 64'h0, pres);
        wait_idle();
        check_counters("zero");
    endtask

    task automatic test_all_ones();
        int pres;
        tx_ready = 1'b1;
        exp_q.push_back(9'h0F3);
        for (int i = 0; i < 9; i++) exp_q.push_back(9'h0FF);
        exp_q.push_back(9'h1BC);
        send_req(3'd7, 64'hFFFF_FFFF_FFFF_FFFF, pres);
        wait_idle();
        check_counters("all_ones");
    endtask

    task automatic test_stall();
        int pres;
        tx_ready = 1'b0;
`ifdef BITS_ENC_FULL_WIDTH_EN
        push_model(3'd1, 64'hF);
`else
        exp_q.push_back(9'h031);
        exp_q.push_back(9'h1E0);
`endif
        send_req(3'd1, 64'hF, pres);
        wait_valid();
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready    = 1'b0;
        req_valid   = 1'b1;
        req_version = 3'd5;
        req_value   = 64'h1234;
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL stall_req_ready: got %b required 0", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++;
        if (state !== SEND || tx_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_state: got state=%0d valid=%b required 2/1", state, tx_valid);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check_counters("stall");
    endtask

    task automatic test_back_to_back();
        int pres;
        logic [63:0] vals[3];
        vals[0] = 64'h7E5;
        vals[1] = 64'h0;
        vals[2] = 64'h0123_4567_89AB_CDEF;
        do_reset();
        gap_q.delete();
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_model(3'd6, vals[i]);
            send_req(3'd6, vals[i], pres);
        end
        wait_idle();
        check_counters("b2b");
        total++;
        if (pkt_count !== 16'd3 || version_sum !== 16'd18) begin
            bad++;
            $display("FAIL b2b_totals: got %0d/%0d required 3/18", pkt_count, version_sum);
        end
        total++;
        if (gap_q.size() != 2) begin
            bad++;
            $display("FAIL b2b_gap_count: got %0d required 2", gap_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (gap_q[i] != 2) begin
                    bad++;
                    $display("FAIL b2b_gap: got %0d required 2", gap_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int pres;
        tx_ready = 1'b1;
        push_7e5();
        send_req(3'd6, 64'h7E5, pres);
        wait_valid();
        @(posedge clk); #1;
        resetB = 1'b0;
        #1;
        total++;
        if (tx_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_outputs: got valid=%b ready=%b required 0/1", tx_valid, req_ready);
        end
        total++;
        if (pkt_count !== 16'd0 || version_sum !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset_counters: got %0d/%0d required 0/0", pkt_count, version_sum);
        end
        exp_q.delete();
        exp_pkt  = 0;
        exp_vsum = 0;
        @(posedge clk); #1;
        resetB = 1'b1;
        push_model(3'd3, 64'hABC);
        send_req(3'd3, 64'hABC, pres);
        wait_idle();
        check_counters("mid_reset_next");
    endtask

    task automatic test_random();
        int pres;
        int k;
        logic [2:0] ver;
        logic [63:0] val;
        for (int t = 0; t < 8; t++) begin
            ver = 3'($urandom_range(0, 7));
            val = {$urandom, $urandom} >> (4 * $urandom_range(0, 16));
            tx_ready = 1'($urandom_range(0, 1));
            push_model(ver, val);
            send_req(ver, val, pres);
            k = 0;
            while (!(state == IDLE && exp_q.size() == 0) && k < 300) begin
                tx_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                k++;
            end
            tx_ready = 1'b1;
            wait_idle();
        end
        check_counters("random");
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_zero();
        test_all_ones();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_bytes: got %0d required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bits_literal_encoder.md
Name: bits_literal_encoder

Overview:
Transmit-side counterpart of the BITS packet decoder. It accepts a (version, 64-bit value) request and serialises one BITS literal packet (type ID 4) as an MSB-first byte stream with zero padding at the end. Leading-zero nibbles are suppressed. Test benches and the instruction-memory loader use it to generate packet images that the decoder FSM then consumes.

Parameters:
VALUE_W, 64, literal value width; must be a multiple of 4.
MAX_NIB, VALUE_W/4, maximum number of 5-bit groups.
MAX_BYTES, (6+5*MAX_NIB+7)/8, shift-register depth in bytes; 11 at the default.

Ports:
clk  input  1  system clock
resetB  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  encoder can accept a request (high only in IDLE)
req_version  input  3  packet version field
req_value  input  VALUE_W  literal value
tx_valid  output  1  tx_data is valid
tx_ready  input  1  downstream accepts the byte
tx_data  output  8  packet byte; bit 7 is the earliest packet bit
tx_last  output  1  final byte of the packet
pkt_count  output  16  packets fully sent
version_sum  output  16  running sum of the versions of sent packets

Behaviour:
- Reset values: state=IDLE, req_ready=1, tx_valid=0, tx_data=0, tx_last=0, pkt_count=0, version_sum=0. All internal registers are cleared.
- Reset asserted mid-packet aborts the packet immediately. No partial packet is counted.
- Request acceptance is req_valid & req_ready at a rising edge. The block latches version and value.
- req_valid is ignored in every state except IDLE.
- States:
  - IDLE:
    - req_ready=1.
    - On acceptance, go to PACK.
  - PACK (1 cycle):
    - N = number of significant nibbles of value, with a minimum of 1. Value 0 gives N=1.
    - Build the packet: {version[2:0], 3'b100}, then N groups, most significant first. Each group is {cont, nibble}, with cont=1 for every group except the last.
    - Load the packet left-justified into the MAX_BYTES*8 shift register, with zero fill.
    - nbytes = ceil((6+5N)/8).
    - Go to SEND. tx_valid rises in the cycle after PACK, i.e. 2 cycles after acceptance.
  - SEND:
    - tx_data = shift register [top 8 bits].
    - tx_last = (bytes_left==1).
    - On tx_valid & tx_ready:
      - Shift left by 8 and decrement bytes_left.
      - If it was the last byte: pkt_count+=1, version_sum+=version, tx_valid drops, go to IDLE.
      - req_ready is high in the cycle after the last byte.
- While tx_valid=1 and tx_ready=0, tx_data and tx_last are held stable.
- tx_valid is never deasserted without a handshake.
- Throughput is 1 byte/cycle when tx_ready is held high. The per-packet overhead is 2 idle cycles (accept + PACK).
- pkt_count and version_sum wrap modulo 2^16 with no saturation.
- If tx_ready is high while tx_valid=0, nothing happens.

Optional Feature:
BITS_ENC_FULL_WIDTH_EN
- Defined: leading-zero suppression is disabled. N=MAX_NIB always, nbytes=MAX_BYTES (11). Value 0 is sent as 16 zero groups, the first 15 of them with cont=1.
- Undefined: minimal-N encoding as described in Behaviour.

Decomposition:
- Package bits_pkg:
  - PKT_TYPE_LITERAL=3'd4
  - Header width 6, group width 5
  - State encoding localparams IDLE=2'd0, PACK=2'd1, SEND=2'd2
  - The MAX_BYTES helper function
- One sub-module, bits_nibble_count: combinational leading-nibble priority encoder, VALUE_W → N (5 bits, minimum 1).

Test Plan:
- version=6, value=0x7E5 with tx_ready held high:
  - bytes D2 FE 28, tx_last on 0x28.
  - tx_valid first high 2 cycles after acceptance.
  - pkt_count=1, version_sum=6.
- version=0, value=0: bytes 10 00, tx_last on the second byte. With BITS_ENC_FULL_WIDTH_EN: 11 bytes, first byte 0x12.
- version=7, value=0xFFFF_FFFF_FFFF_FFFF: 11 bytes, first byte F3, tx_last only on byte 11. The final byte has zero padding in its low 2 bits.
- version=1, value=0xF with tx_ready toggling 1,0,0,1:
  - Bytes 31 E0.
  - tx_data/tx_last held stable across the stall.
  - A req_valid pulse during SEND is ignored (req_ready=0) and pkt_count increments once.
- Back-to-back: 3 requests presented as soon as req_ready rises (version=6 each):
  - pkt_count=3, version_sum=18.
  - Exactly 2 idle cycles between packets.
- resetB pulsed low during the second byte of a 3-byte packet: tx_valid=0 and req_ready=1 immediately. Counters read 0, and the next request encodes correctly.
